// File: rtl/decoder_scan_sequencer.sv
// Drives the select code {a,b,c} and enable e of a 3-to-8 decoder, stepping
// through the outputs at a prescaled rate in up, down, bounce or hold order.
module decoder_scan_sequencer #(
  parameter int TICK_DIV  = 4,
  parameter int DIV_WIDTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic [1:0] mode,
  input  logic       load,
  input  logic [2:0] load_val,
  output logic       e,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       step_tick,
  output logic       wrap
);

  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

  localparam logic [1:0] MODE_UP     = 2'b00;
  localparam logic [1:0] MODE_DOWN   = 2'b01;
  localparam logic [1:0] MODE_BOUNCE = 2'b10;
  localparam logic       DIR_UP      = 1'b0;
  localparam logic       DIR_DOWN    = 1'b1;
  localparam logic [DIV_WIDTH-1:0] TERM = DIV_WIDTH'(TICK_DIV - 1);

  state_t               state_q, state_d;
  logic [2:0]           pos_q, pos_d;
  logic                 dir_q, dir_d;
  logic [DIV_WIDTH-1:0] presc_q, presc_d;
  logic                 tick_q, tick_d;
  logic                 wrap_q, wrap_d;

  // Load wins over stepping; otherwise a step happens on prescaler terminal count.
  always_comb begin
    state_d = run ? ACTIVE : IDLE;
    pos_d   = pos_q;
    dir_d   = dir_q;
    presc_d = presc_q;
    tick_d  = 1'b0;
    wrap_d  = 1'b0;
    if (load) begin
      pos_d   = load_val;
      presc_d = '0;
      dir_d   = DIR_UP;
    end else if (run) begin
      if (presc_q == TERM) begin
        presc_d = '0;
        tick_d  = 1'b1;
        case (mode)
          MODE_UP: begin
            pos_d  = pos_q + 3'd1;
            wrap_d = (pos_q == 3'd7);
          end
          MODE_DOWN: begin
            pos_d  = pos_q - 3'd1;
            wrap_d = (pos_q == 3'd0);
          end
          MODE_BOUNCE: begin
            if (dir_q == DIR_UP) begin
              if (pos_q == 3'd7) begin
                pos_d  = 3'd6;
                dir_d  = DIR_DOWN;
                wrap_d = 1'b1;
              end else begin
                pos_d = pos_q + 3'd1;
              end
            end else begin
              if (pos_q == 3'd0) begin
                pos_d  = 3'd1;
                dir_d  = DIR_UP;
                wrap_d = 1'b1;
              end else begin
                pos_d = pos_q - 3'd1;
              end
            end
          end
          default: begin
            pos_d = pos_q;
          end
        endcase
      end else begin
        presc_d = presc_q + DIV_WIDTH'(1);
      end
    end else begin
      presc_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pos_q   <= 3'd0;
      dir_q   <= DIR_UP;
      presc_q <= '0;
      tick_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      dir_q   <= dir_d;
      presc_q <= presc_d;
      tick_q  <= tick_d;
      wrap_q  <= wrap_d;
    end
  end

  // The one-bit state flop doubles as the decoder enable.
  assign e         = (state_q == ACTIVE);
  assign a         = pos_q[2];
  assign b         = pos_q[1];
  assign c         = pos_q[0];
  assign step_tick = tick_q;
  assign wrap      = wrap_q;

endmodule

// File: tb/tb_decoder_scan_sequencer.sv
// Directed bench: one instance at TICK_DIV=4 for the main sequences and a
// second at TICK_DIV=1 for the hold/every-edge stepping case.
module tb_decoder_scan_sequencer;

  logic       clk;
  logic       rst_n;
  logic       run, load;
  logic [1:0] mode;
  logic [2:0] loadVal;
  logic       e, a, b, c, stepTick, wrap;
  logic       run1, load1;
  logic [1:0] mode1;
  logic [2:0] loadVal1;
  logic       e1, a1, b1, c1, stepTick1, wrap1;
  logic [2:0] abc, abc1;
  int         checks, errors;

  assign abc  = {a, b, c};
  assign abc1 = {a1, b1, c1};

  decoder_scan_sequencer #(.TICK_DIV(4), .DIV_WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .mode(mode), .load(load),
    .load_val(loadVal), .e(e), .a(a), .b(b), .c(c),
    .step_tick(stepTick), .wrap(wrap)
  );

  decoder_scan_sequencer #(.TICK_DIV(1), .DIV_WIDTH(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .run(run1), .mode(mode1), .load(load1),
    .load_val(loadVal1), .e(e1), .a(a1), .b(b1), .c(c1),
    .step_tick(stepTick1), .wrap(wrap1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed != expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Advance n rising edges and settle just after the last one.
  task automatic applyStimulus(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int tickCount, wrapCount, p;
    int bouncePos[10]  = '{7, 6, 5, 4, 3, 2, 1, 0, 1, 2};
    int bounceWrap[10] = '{0, 1, 0, 0, 0, 0, 0, 0, 1, 0};
    checks = 0;
    errors = 0;
    run = 0; load = 0; mode = 2'b00; loadVal = 3'd0;
    run1 = 0; load1 = 0; mode1 = 2'b00; loadVal1 = 3'd0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    checkOutput("reset_e", int'(e), 0);
    checkOutput("reset_abc", int'(abc), 0);
    checkOutput("reset_tick", int'(stepTick), 0);
    checkOutput("reset_wrap", int'(wrap), 0);
    applyStimulus(2);
    rst_n = 1'b1;
    applyStimulus(3);
    checkOutput("idle_e", int'(e), 0);
    checkOutput("idle_abc", int'(abc), 0);

    // Up count from reset: step every 4th edge, wrap on 7->0
    run = 1; mode = 2'b00;
    tickCount = 0; wrapCount = 0;
    for (int k = 1; k <= 32; k++) begin
      applyStimulus(1);
      checkOutput("up_e", int'(e), 1);
      checkOutput("up_abc", int'(abc), (k / 4) % 8);
      checkOutput("up_tick", int'(stepTick), (k % 4 == 0) ? 1 : 0);
      checkOutput("up_wrap", int'(wrap), (k == 32) ? 1 : 0);
      tickCount += int'(stepTick);
      wrapCount += int'(wrap);
    end
    checkOutput("up_tick_total", tickCount, 8);
    checkOutput("up_wrap_total", wrapCount, 1);

    // Asynchronous reset mid-count at pos=5, prescaler=2
    applyStimulus(22);
    checkOutput("pre_reset_abc", int'(abc), 5);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_e", int'(e), 0);
    checkOutput("async_abc", int'(abc), 0);
    checkOutput("async_tick", int'(stepTick), 0);
    checkOutput("async_wrap", int'(wrap), 0);
    run = 0;
    applyStimulus(1);
    rst_n = 1'b1;
    applyStimulus(3);
    checkOutput("post_reset_e", int'(e), 0);
    checkOutput("post_reset_abc", int'(abc), 0);

    // Down: load 0 then first step gives 7 with wrap
    run = 1; mode = 2'b01; load = 1; loadVal = 3'd0;
    applyStimulus(1);
    load = 0;
    checkOutput("down_load_abc", int'(abc), 0);
    checkOutput("down_load_tick", int'(stepTick), 0);
    applyStimulus(3);
    checkOutput("down_mid_abc", int'(abc), 0);
    applyStimulus(1);
    checkOutput("down_abc", int'(abc), 7);
    checkOutput("down_wrap", int'(wrap), 1);
    checkOutput("down_tick", int'(stepTick), 1);
    applyStimulus(1);
    checkOutput("down_wrap_clear", int'(wrap), 0);

    // Bounce from 6 through both turns
    mode = 2'b10; load = 1; loadVal = 3'd6;
    applyStimulus(1);
    load = 0;
    checkOutput("bounce_load_abc", int'(abc), 6);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(4);
      checkOutput("bounce_abc", int'(abc), bouncePos[i]);
      checkOutput("bounce_wrap", int'(wrap), bounceWrap[i]);
    end

    // Pause at pos=3, prescaler=2, then resume
    mode = 2'b00; load = 1; loadVal = 3'd3;
    applyStimulus(1);
    load = 0;
    applyStimulus(2);
    run = 0;
    applyStimulus(1);
    checkOutput("pause_e", int'(e), 0);
    checkOutput("pause_abc", int'(abc), 3);
    applyStimulus(9);
    checkOutput("pause_hold_abc", int'(abc), 3);
    checkOutput("pause_tick", int'(stepTick), 0);
    run = 1;
    applyStimulus(1);
    checkOutput("resume_e", int'(e), 1);
    applyStimulus(2);
    checkOutput("resume_mid_abc", int'(abc), 3);
    applyStimulus(1);
    checkOutput("resume_abc", int'(abc), 4);
    checkOutput("resume_tick", int'(stepTick), 1);

    // Load on the same edge as a terminal count
    applyStimulus(3);
    load = 1; loadVal = 3'd5;
    applyStimulus(1);
    load = 0;
    checkOutput("loadpri_abc", int'(abc), 5);
    checkOutput("loadpri_tick", int'(stepTick), 0);
    checkOutput("loadpri_wrap", int'(wrap), 0);
    applyStimulus(3);
    checkOutput("loadpri_wait_abc", int'(abc), 5);
    applyStimulus(1);
    checkOutput("loadpri_step_abc", int'(abc), 6);
    checkOutput("loadpri_step_tick", int'(stepTick), 1);

    // TICK_DIV=1 instance: hold then up every edge
    run1 = 1; mode1 = 2'b11; load1 = 1; loadVal1 = 3'd2;
    applyStimulus(1);
    load1 = 0;
    checkOutput("fast_load_abc", int'(abc1), 2);
    checkOutput("fast_load_tick", int'(stepTick1), 0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1);
      checkOutput("hold_tick", int'(stepTick1), 1);
      checkOutput("hold_abc", int'(abc1), 2);
    end
    mode1 = 2'b00;
    p = 2;
    wrapCount = 0;
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1);
      checkOutput("fast_wrap", int'(wrap1), (p == 7) ? 1 : 0);
      p = (p + 1) % 8;
      checkOutput("fast_abc", int'(abc1), p);
      checkOutput("fast_tick", int'(stepTick1), 1);
      wrapCount += int'(wrap1);
    end
    checkOutput("fast_wrap_total", wrapCount, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
